// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding, width limits and counter sizing for serial_adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // Bits needed to count 0..w-1; never less than one so WIDTH=1 still has a counter.
    function automatic int cnt_width(input int w);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << n) < w) begin
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - one-bit full adder built from two half-adder stages
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    assign s1   = a ^ b;
    assign c1   = a & b;
    assign s    = s1 ^ cin;
    assign c2   = s1 & cin;
    assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder/subtractor with carry-out and signed overflow
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;

    full_adder_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign accept   = start && (state == IDLE || state == DONE);
    assign last     = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign res_next = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Subtraction is a + ~b + 1: invert B on load and seed the carry with sub.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            res   <= res_next;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= res_next;
                cout <= fa_c;
                ovf  <= carry ^ fa_c;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
